// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of a dual-clock FIFO. It synchronises the producer's Gray write
// pointer, sequences synchronous RAM reads into a valid/ready stream and publishes a Gray read pointer.
module fifo_rd_ctrl #(
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W:0]   wr_ptr_gray_async,
   output logic [ADDR_W:0]   rd_ptr_gray,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   input  logic              flush,
   output logic              empty,
   output logic [ADDR_W:0]   level
);

   localparam int PW = ADDR_W + 1;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Plain flop chain: no logic between stages, so only the last stage is decoded.
   logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
   logic [PW-1:0]                  wr_bin_sync;

   logic [PW-1:0] rd_bin_q,  rd_bin_d;
   logic [PW-1:0] rd_gray_q, rd_gray_d;
   logic          valid_q,   valid_d;
   logic          rd_en;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], wr_ptr_gray_async};
      end
   end

   // NOTE: the every-branch default at the top of always_comb is what keeps it latch-free.
   always_comb begin
      wr_bin_sync = gray2bin(sync_q[SYNC_STAGES-1]);
      rd_en       = 1'b0;
      rd_bin_d    = rd_bin_q;
      valid_d     = valid_q;

      rd_en = (rd_bin_q != wr_bin_sync) & ~flush & (~valid_q | dout_ready);

      if (flush) begin
         rd_bin_d = wr_bin_sync;
         valid_d  = 1'b0;
      end else begin
         rd_bin_d = rd_bin_q + {{ADDR_W{1'b0}}, rd_en};
         valid_d  = rd_en | (valid_q & ~dout_ready);
      end

      rd_gray_d = bin2gray(rd_bin_d);
   end

   // NOTE: the FIFO RAM is never reset; the pointers alone decide which words are valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_bin_q  <= '0;
         rd_gray_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         rd_bin_q  <= rd_bin_d;
         rd_gray_q <= rd_gray_d;
         valid_q   <= valid_d;
      end
   end

   assign empty       = (rd_bin_q == wr_bin_sync);
   assign level       = wr_bin_sync - rd_bin_q;
   assign mem_rd_en   = rd_en;
   assign mem_rd_addr = rd_bin_q[ADDR_W-1:0];
   assign rd_ptr_gray = rd_gray_q;
   assign dout        = mem_rd_data;
   assign dout_valid  = valid_q;

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller of the dual-clock FIFOs in the MPEG path. It runs entirely in the consumer clock domain and owns the synchronous-read FIFO RAM read port. It synchronises the producer's Gray-coded write pointer, derives the empty flag and fill level, sequences RAM reads into a valid/ready output stream, and publishes its own Gray-coded read pointer for the producer side.

Parameters:
ADDR_W, 4, RAM address width; depth is 2^ADDR_W and pointers are ADDR_W+1 bits.
SYNC_STAGES, 2, flop stages on the incoming write pointer (legal values 2..3).
DATA_W, 32, word width.

Ports:
clk  in  1  consumer clock.
reset  in  1  asynchronous, active-high reset.
wr_ptr_gray_async  in  ADDR_W+1  producer write pointer, Gray-coded, asynchronous to clk.
rd_ptr_gray  out  ADDR_W+1  registered Gray read pointer for the producer domain.
mem_rd_en  out  1  RAM read strobe. Data appears on mem_rd_data one cycle later and the RAM holds it while the strobe is low.
mem_rd_addr  out  ADDR_W  RAM read address.
mem_rd_data  in  DATA_W  RAM read data.
dout  out  DATA_W  output word; equals mem_rd_data.
dout_valid  out  1  dout holds an unconsumed word.
dout_ready  in  1  consumer accepts dout.
flush  in  1  synchronous discard of all buffered data.
empty  out  1  no unread word in RAM (excludes the word held on dout).
level  out  ADDR_W+1  words in RAM not yet read: wr_bin_sync - rd_bin, modulo 2^(ADDR_W+1).

Behaviour:
- Reset (async assert; released on a clk edge):
  - all synchroniser flops, rd_bin, rd_ptr_gray, dout_valid and level are 0; empty is 1.
  - mem_rd_en is 0 while reset is asserted.
  - A reset mid-stream drops dout_valid immediately; no handshake is completed.
- Synchroniser:
  - wr_ptr_gray_async passes through SYNC_STAGES flops with no logic between stages.
  - The Gray-to-binary conversion applies only to the last stage, giving wr_bin_sync.
- Internal state:
  - rd_bin: ADDR_W+1-bit binary read pointer.
  - empty = (rd_bin == wr_bin_sync), combinational from registers.
  - level: combinational subtraction, wraps naturally.
- Read issue:
  - mem_rd_en = ~empty & ~flush & (~dout_valid | dout_ready).
  - mem_rd_addr = rd_bin[ADDR_W-1:0].
  - On a clk edge with mem_rd_en=1, rd_bin increments by 1, wrapping 2^(ADDR_W+1)-1 to 0.
- Output register:
  - Next dout_valid = flush ? 0 : (mem_rd_en | (dout_valid & ~dout_ready)).
  - Full throughput is one word per cycle while data is available and dout_ready is held high.
  - While dout_valid=1 and dout_ready=0, no read is issued and dout stays stable.
- rd_ptr_gray is registered as the binary-to-Gray conversion of the next rd_bin value. It changes by exactly one bit per increment and never glitches.
- Latency: the write pointer is stable before edge k. wr_bin_sync updates at edge k+SYNC_STAGES-1, mem_rd_en rises in the following cycle, and dout_valid rises at edge k+SYNC_STAGES.
- Flush, for one cycle:
  - rd_bin is loaded with wr_bin_sync and dout_valid is cleared at the next edge.
  - No read is issued that cycle.
  - Flush takes priority over a simultaneous dout_ready handshake, which is not counted.
- Full FIFO: level = 2^ADDR_W reads correctly. The controller never reads past wr_bin_sync.
- Pointer wrap: the MSB of the pointers differs between the two laps, so empty and level remain correct across the wrap.

Test Plan:
- Reset check, ADDR_W=4, SYNC_STAGES=2: assert reset mid-run → rd_ptr_gray=0, dout_valid=0, empty=1, level=0 with no clock edge needed.
- Single word: wr_ptr_gray_async goes 0→1 before edge k, dout_ready=0 → mem_rd_en high in cycle k+1 with addr 0; dout_valid=1 after edge k+2; level returns to 0; rd_ptr_gray=1.
- Streaming: write pointer jumps to 8 (Gray 0x0C) with dout_ready=1 → 8 consecutive mem_rd_en cycles on addresses 0..7; dout_valid high 8 consecutive cycles; rd_ptr_gray ends at 0x0C.
- Backpressure: 3 words available, dout_ready toggled 1,0,0,1,1 → dout is held stable through the stall, no read is issued while stalled, and exactly 3 handshakes complete in order.
- Wrap and full: cycle the pointers through 40 words (past 31→0), then leave 16 unread → level=16 and empty=0. Draining gives addresses 8..15,0..7 in order, after which empty=1.
- Flush: 5 words buffered, dout_valid=1, flush pulsed together with dout_ready=1 → next cycle dout_valid=0, level=0, empty=1, rd_ptr_gray=wr_ptr_gray, and no handshake is counted.
